// File: rtl/seq1001_pkg.sv
// Shared state encoding, pattern constant and transition function for the
// 1001 serial pattern detector.
package seq1001_pkg;

    localparam int STATE_W = 3;
    localparam logic [3:0] PATTERN = 4'b1001;

    // Each state records how much of PATTERN (MSB first) has been seen so far.
    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    function automatic state_t next_state(input state_t cur, input logic x);
        // NOTE: the default arm gives every path a value, so combinational
        // users of this function can never infer a latch; it also recovers
        // the unused codes 5-7 to S0.
        case (cur)
            S0:      return (x == PATTERN[3]) ? S1 : S0;
            S1:      return (x == PATTERN[2]) ? S2 : S1;
            S2:      return (x == PATTERN[1]) ? S3 : S1;
            S3:      return (x == PATTERN[0]) ? S4 : S0;
            // The trailing 1 of a match doubles as the leading 1 of the next.
            S4:      return x ? S1 : S2;
            default: return S0;
        endcase
    endfunction

endpackage

// File: rtl/seq1001_detector_sat_counter.sv
// Saturating event counter used by seq1001_detector when SEQ_MATCH_CNT_EN
// is defined; the module is absent otherwise.
`ifdef SEQ_MATCH_CNT_EN
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Holds at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/seq1001_detector.sv
// Moore detector for the overlapping serial pattern 1001 with a registered
// one-cycle match flag. Define SEQ_MATCH_CNT_EN to add a saturating match_count.
module seq1001_detector
    import seq1001_pkg::*;
`ifdef SEQ_MATCH_CNT_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic             clock,
    input  logic             reset,
    input  logic             x,
`ifdef SEQ_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_count,
`endif
    output logic             y
);

    state_t state;
    state_t state_nxt;

    assign state_nxt = next_state(state, x);

    // y is registered from the next state so it equals (state == S4) exactly.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // independent of statement order within the block.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S0;
            y     <= 1'b0;
        end else begin
            state <= state_nxt;
            y     <= (state_nxt == S4);
        end
    end

`ifdef SEQ_MATCH_CNT_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (state_nxt == S4),
        .count (match_count)
    );
`endif

endmodule

// File: tb/tb_seq1001_detector.sv
// Self-checking bench for seq1001_detector: directed tables plus random
// stimulus against a last-four-bits history model. Honours SEQ_MATCH_CNT_EN.
`timescale 1ns/1ps
module tb_seq1001_detector;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic x     = 1'b0;
    logic y;
`ifdef SEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] match_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

`ifdef SEQ_MATCH_CNT_EN
    seq1001_detector #(
        .CNT_W (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .x           (x),
        .match_count (match_count),
        .y           (y)
    );
`else
    seq1001_detector dut (
        .clock (clock),
        .reset (reset),
        .x     (x),
        .y     (y)
    );
`endif

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: a match is simply "the last four bits since reset read 1001".
    logic [3:0] hist  = 4'b0;
    int         nbits = 0;
    int         exp_cnt = 0;
    logic       model_y;

    assign model_y = (nbits >= 4) && (hist == 4'b1001);

    always @(posedge clock or negedge reset) begin
        logic [3:0] h;
        if (!reset) begin
            hist    <= 4'b0;
            nbits   <= 0;
            exp_cnt <= 0;
        end else begin
            h = {hist[2:0], x};
            hist  <= h;
            nbits <= (nbits < 4) ? nbits + 1 : 4;
            if ((nbits >= 3) && (h == 4'b1001) && (exp_cnt < CNT_MAX))
                exp_cnt <= exp_cnt + 1;
        end
    end

    // Continuous comparison on the falling edge, away from the active edge.
    logic prev_y = 1'b0;
    always @(negedge clock) begin
        check("y_vs_model", int'(y), int'(model_y));
        check("y_not_twice", int'(prev_y && y), 0);
`ifdef SEQ_MATCH_CNT_EN
        check("count_vs_model", int'(match_count), exp_cnt);
`endif
        prev_y <= y;
    end

    // Applies bits MSB-first and checks y against a hand-written table
    // one step after each rising edge.
    task automatic run_seq(input string name, input logic [31:0] bits,
                           input logic [31:0] ys, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            x = bits[n-1-i];
            @(posedge clock);
            #1;
            check(name, int'(y), int'(ys[n-1-i]));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b0;
        x     = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] hold_bits;
        hold_bits = 8'b1001_0110;

        // Held in reset: x ignored, y and count stay at zero.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            x = hold_bits[7-i];
            @(posedge clock);
            #1;
            check("hold_y", int'(y), 0);
`ifdef SEQ_MATCH_CNT_EN
            check("hold_count", int'(match_count), 0);
`endif
        end
        @(negedge clock);
        reset = 1'b1;

        // Single match, then a 0 drops y.
        run_seq("single", 32'b10010, 32'b00010, 5);
        check("model_pin_single", int'(model_y), 0);

        // Overlapping matches three cycles apart.
        pulse_reset();
        run_seq("overlap", 32'b1001001, 32'b0001001, 7);
        check("model_pin_overlap", int'(model_y), 1);
`ifdef SEQ_MATCH_CNT_EN
        check("overlap_count", int'(match_count), 2);
`endif

        // S2 -> S1 restart, and S1 self-loop.
        pulse_reset();
        run_seq("restart", 32'b101001, 32'b000001, 6);
        pulse_reset();
        run_seq("self_loop", 32'b11001, 32'b00001, 5);

        // Asynchronous reset mid-prefix discards "100".
        pulse_reset();
        run_seq("prefix", 32'b100, 32'b000, 3);
        #2 reset = 1'b0;
        #1 check("async_mid_y", int'(y), 0);
        @(negedge clock);
        reset = 1'b1;
        run_seq("after_rst", 32'b1, 32'b0, 1);
        run_seq("after_rst_full", 32'b1001, 32'b0001, 4);

        // Reset clears a high y immediately, without a clock edge.
        check("y_high_before_rst", int'(y), 1);
        #2 reset = 1'b0;
        #1 check("async_clear_y", int'(y), 0);
`ifdef SEQ_MATCH_CNT_EN
        check("async_clear_count", int'(match_count), 0);
`endif
        @(negedge clock);
        reset = 1'b1;

        // Five overlapping matches; counter saturates at 3.
        begin
            logic [31:0] bits5;
            int          pulses;
            int          cnt_seq [5];
            bits5  = 32'b1001001001001001;
            pulses = 0;
            cnt_seq = '{1, 2, 3, 3, 3};
            for (int i = 0; i < 16; i++) begin
                @(negedge clock);
                x = bits5[15-i];
                @(posedge clock);
                #1;
                if (y) begin
`ifdef SEQ_MATCH_CNT_EN
                    if (pulses < 5)
                        check("sat_count", int'(match_count), cnt_seq[pulses]);
`endif
                    pulses++;
                end
            end
            check("five_pulses", pulses, 5);
        end

        // Random traffic with occasional mid-cycle resets.
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            reset = 1'b1;
            x = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b0;
            end
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
